// File: rtl/gcd_job_master.sv
// GCD job master: takes an operand pair, drives an Avalon-MM GCD slave
// (write A, write B, poll status, read result) and returns the result
// through a valid/ready output port. Zero operands are resolved locally.
module gcd_job_master #(
  parameter int unsigned TIMEOUT      = 1023,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_gcd,
  output logic        out_err,
  output logic [1:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic [15:0] job_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned JOB_W  = 16;
  localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] ADDR_OP_A   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_OP_B   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_RESULT = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd3;

  // The datapath samples read data in the cycle right after acceptance only.
  if (READ_LATENCY != 1) begin : g_bad_read_latency
    $error("gcd_job_master supports READ_LATENCY == 1 only");
  end

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, POLL, POLL_WAIT, RD_RES, RD_WAIT, OUT
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   gcd_q, gcd_d;
  logic                err_q, err_d;
  logic [JOB_W-1:0]    job_q, job_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  // State and registered outputs; async active-low reset abandons any job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      gcd_q       <= '0;
      err_q       <= 1'b0;
      job_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      gcd_q       <= gcd_d;
      err_q       <= err_d;
      job_q       <= job_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Next state, datapath updates, and output values decoded from the next state.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    gcd_d       = gcd_q;
    err_d       = err_q;
    job_d       = job_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d = in_a;
          b_d = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            gcd_d   = in_a | in_b;
            err_d   = 1'b0;
            state_d = OUT;
          end else begin
            state_d = WR_A;
          end
        end
      end
      WR_A: begin
        if (!avm_waitrequest) state_d = WR_B;
      end
      WR_B: begin
        if (!avm_waitrequest) begin
          cnt_d   = '0;
          state_d = POLL;
        end
      end
      POLL: begin
        if (!avm_waitrequest) state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (avm_readdata[0]) begin
          state_d = RD_RES;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            gcd_d   = '0;
            err_d   = 1'b1;
            state_d = OUT;
          end else begin
            state_d = POLL;
          end
        end
      end
      RD_RES: begin
        if (!avm_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        gcd_d   = avm_readdata;
        err_d   = 1'b0;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          job_d   = job_q + JOB_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == OUT);

    case (state_d)
      WR_A: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_OP_A;
        wdata_d = a_d;
      end
      WR_B: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_OP_B;
        wdata_d = b_d;
      end
      POLL: begin
        rd_d   = 1'b1;
        addr_d = ADDR_STATUS;
      end
      RD_RES: begin
        rd_d   = 1'b1;
        addr_d = ADDR_RESULT;
      end
      default: begin
        wr_d = 1'b0;
        rd_d = 1'b0;
      end
    endcase
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_gcd        = gcd_q;
  assign out_err        = err_q;
  assign avm_address    = addr_q;
  assign avm_write      = wr_q;
  assign avm_read       = rd_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;
  assign busy           = busy_q;
  assign job_count      = job_q;

endmodule

// File: tb/tb_gcd_job_master.sv
// Bench for gcd_job_master: Avalon GCD slave model, vector table, scoreboard
// of expected results, and hand-written waitrequest/backpressure/reset sequences.
module tb_gcd_job_master;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_gcd;
  logic        out_err;
  logic [1:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic [15:0] job_count;

  gcd_job_master #(.TIMEOUT(TO), .READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .job_count(job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          done_at;
    logic [31:0] gcd;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] gcd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_jobs = 0;

  // Slave model state
  logic [31:0] slv_a = '0;
  logic [31:0] slv_b = '0;
  logic [31:0] slv_rdata = 32'hDEADBEE0;
  int          slv_done_at = 1;
  int          poll_num = 0;
  int          n_wr_a = 0, n_wr_b = 0, n_stat = 0, n_res = 0, n_req = 0, n_overlap = 0;

  assign avm_readdata = slv_rdata;

  function automatic logic [31:0] gcd_ref(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p, q, t;
    p = x;
    q = y;
    while (q != 32'd0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Avalon slave: register file, status done after slv_done_at polls, 1-cycle read data.
  always @(posedge clk) begin
    slv_rdata <= 32'hDEADBEE0;
    if (avm_read && avm_write) n_overlap <= n_overlap + 1;
    if (avm_read || avm_write) n_req <= n_req + 1;
    if (!avm_waitrequest) begin
      if (avm_write) begin
        if (avm_address == 2'd0) begin
          slv_a  <= avm_writedata;
          n_wr_a <= n_wr_a + 1;
        end else if (avm_address == 2'd1) begin
          slv_b    <= avm_writedata;
          n_wr_b   <= n_wr_b + 1;
          poll_num <= 0;
        end
      end
      if (avm_read) begin
        if (avm_address == 2'd3) begin
          n_stat    <= n_stat + 1;
          poll_num  <= poll_num + 1;
          slv_rdata <= {31'd0, (slv_done_at != 0) && (poll_num + 1 >= slv_done_at)};
        end else if (avm_address == 2'd2) begin
          n_res     <= n_res + 1;
          slv_rdata <= gcd_ref(slv_a, slv_b);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic abort_run(input string name);
    errors++;
    $display("FAIL %s: wait bound expired", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Pop the scoreboard at an observed output handshake and compare.
  task automatic sb_pop_check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got output gcd=0x%0h with nothing expected", out_gcd);
    end else begin
      e = sb.pop_front();
      chk("out_gcd", out_gcd, e.gcd);
      chk("out_err", 32'(out_err), 32'(e.err));
      exp_jobs++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_gcd"},   out_gcd, 32'd0);
    chk({tag, "_out_err"},   32'(out_err), 32'd0);
    chk({tag, "_avm_read"},  32'(avm_read), 32'd0);
    chk({tag, "_avm_write"}, 32'(avm_write), 32'd0);
    chk({tag, "_avm_addr"},  32'(avm_address), 32'd0);
    chk({tag, "_avm_wdata"}, avm_writedata, 32'd0);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_job_count"}, 32'(job_count), 32'd0);
  endtask

  // Offer one job, optionally stall WR_A and/or hold out_ready low, then check everything.
  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int done_at,
                         input int stall, input int hold, input logic [31:0] eg,
                         input logic ee, input int exp_lat);
    int wa0, wb0, st0, rs0, rq0, lat, exp_stat;
    bit hs, ov, zero;
    exp_t e;
    wa0 = n_wr_a; wb0 = n_wr_b; st0 = n_stat; rs0 = n_res; rq0 = n_req;
    zero = (a == 32'd0) || (b == 32'd0);
    slv_done_at = done_at;
    e.gcd = eg;
    e.err = ee;
    sb.push_back(e);
    @(posedge clk); #1;
    in_a = a; in_b = b; in_valid = 1'b1;
    out_ready = (hold == 0);
    if (stall > 0) avm_waitrequest = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      if (in_ready) hs = 1'b1;
    end
    if (!hs) abort_run("in_handshake");
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      lat++;
      chk("stall_write", 32'(avm_write), 32'd1);
      chk("stall_addr", 32'(avm_address), 32'd0);
      chk("stall_wdata", avm_writedata, a);
      chk("stall_no_wrb", 32'(n_wr_b - wb0), 32'd0);
    end
    avm_waitrequest = 1'b0;
    ov = 1'b0;
    for (int i = 0; i < 300 && !ov; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) ov = 1'b1;
    end
    if (!ov) abort_run("out_valid_wait");
    if (exp_lat != 0) chk("latency", 32'(lat), 32'(exp_lat));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (i > 0) @(negedge clk);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_gcd", out_gcd, eg);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    if (out_valid && out_ready) sb_pop_check();
    else abort_run("out_handshake");
    @(negedge clk);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("job_count", 32'(job_count), 32'(exp_jobs));
    exp_stat = zero ? 0 : ((done_at == 0) ? int'(TO) : done_at);
    chk("wr_a_count", 32'(n_wr_a - wa0), zero ? 32'd0 : 32'd1);
    chk("wr_b_count", 32'(n_wr_b - wb0), zero ? 32'd0 : 32'd1);
    chk("status_reads", 32'(n_stat - st0), 32'(exp_stat));
    chk("result_reads", 32'(n_res - rs0), (zero || done_at == 0) ? 32'd0 : 32'd1);
    if (zero) chk("no_avm_access", 32'(n_req - rq0), 32'd0);
    else begin
      chk("slave_a", slv_a, a);
      chk("slave_b", slv_b, b);
    end
  endtask

  initial begin
    #400000;
    abort_run("global_watchdog");
  end

  initial begin
    vec_t vecs[11];
    int   nv;
    bit   seen;
    vecs[0]  = '{32'd91,         32'd21,         4, 32'd7,          1'b0, 0};
    vecs[1]  = '{32'd1,          32'd1,          1, 32'd1,          1'b0, 7};
    vecs[2]  = '{32'd2,          32'd1023,       1, 32'd1,          1'b0, 7};
    vecs[3]  = '{32'd0,          32'd45,         1, 32'd45,         1'b0, 1};
    vecs[4]  = '{32'd45,         32'd0,          1, 32'd45,         1'b0, 1};
    vecs[5]  = '{32'd0,          32'd0,          1, 32'd0,          1'b0, 1};
    vecs[6]  = '{32'd12,         32'd18,         8, 32'd6,          1'b0, 0};
    vecs[7]  = '{32'd12,         32'd18,         0, 32'd0,          1'b1, 0};
    vecs[8]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  2, 32'hFFFF_FFFF,  1'b0, 0};
    vecs[9]  = '{32'd48,         32'd180,        3, 32'd12,         1'b0, 0};
    vecs[10] = '{32'd1071,       32'd462,        1, 32'd21,         1'b0, 7};
    nv = 11;

    rst = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1;
    avm_waitrequest = 1'b0;
    #3;
    check_all_zero("reset");
    chk("byteenable", 32'(avm_byteenable), 32'hF);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_in_ready", 32'(in_ready), 32'd1);
    chk("first_edge_busy", 32'(busy), 32'd0);

    for (int i = 0; i < nv; i++)
      run_job(vecs[i].a, vecs[i].b, vecs[i].done_at, 0, 0, vecs[i].gcd, vecs[i].err, vecs[i].lat);

    // Waitrequest held for 5 cycles while writing operand A
    run_job(32'd30, 32'd12, 1, 5, 0, 32'd6, 1'b0, 0);
    // Output backpressure, zero-operand and nonzero
    run_job(32'd0, 32'd45, 1, 0, 4, 32'd45, 1'b0, 1);
    run_job(32'd91, 32'd21, 1, 0, 4, 32'd7, 1'b0, 7);

    // Reset in the middle of polling
    slv_done_at = 0;
    @(posedge clk); #1;
    in_a = 32'd12; in_b = 32'd18; in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
    end
    if (!seen) abort_run("rst_job_handshake");
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (avm_read && avm_address == 2'd3) seen = 1'b1;
    end
    if (!seen) abort_run("rst_wait_poll");
    #2 rst = 1'b0;
    #1;
    check_all_zero("midjob_reset");
    sb.delete();
    exp_jobs = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("rerelease_in_ready", 32'(in_ready), 32'd1);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("abandoned_no_output", 32'(nv), 32'd0);
    run_job(32'd1, 32'd1, 1, 0, 0, 32'd1, 1'b0, 7);

    chk("rd_wr_overlap_cycles", 32'(n_overlap), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
